// File: rtl/dds_cmd_pkg.sv
// Shared types and constants for the DDS command parser.
package dds_cmd_pkg;

  // Frame parser states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_t;

  // Frame framing constants
  localparam logic [7:0] CMD_HDR0     = 8'h55;
  localparam logic [7:0] CMD_HDR1     = 8'hAA;
  localparam logic [7:0] CMD_ADDR_MAX = 8'h0C;
  localparam int         FRAME_LEN    = 8;

  // DDS control register map
  localparam logic [7:0] REG_AMP   = 8'h00;
  localparam logic [7:0] REG_FREQ  = 8'h04;
  localparam logic [7:0] REG_MIN   = 8'h08;
  localparam logic [7:0] REG_PHASE = 8'h0C;

  // Register addresses must be word aligned and inside the map
  function automatic logic addr_legal(input logic [7:0] addr,
                                      input logic [7:0] addr_max);
    return (addr[1:0] == 2'b00) && (addr <= addr_max);
  endfunction

endpackage

// File: rtl/dds_cmd_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// flags the terminal count TIMEOUT_CYC-1.
module dds_cmd_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Terminal count only matters while the watchdog is armed
  assign tc = en && (cnt == TC_VAL);

  // Counter sits at zero when disabled; wraps after terminal count so a
  // stale value never survives into the next frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr || !en) cnt <= '0;
    else if (cnt == TC_VAL)    cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dds_cmd_parser.sv
// UART byte stream -> DDS register-write parser.
// Frame: HDR0 HDR1 ADDR D3 D2 D1 D0 CSUM, CSUM = 8-bit sum of ADDR..D0.
module dds_cmd_parser
  import dds_cmd_pkg::*;
#(
  parameter logic [7:0] HDR0        = CMD_HDR0,
  parameter logic [7:0] HDR1        = CMD_HDR1,
  parameter logic [7:0] ADDR_MAX    = CMD_ADDR_MAX,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        wr_vld,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        csum_err,
  output logic        addr_err,
  output logic        timeout_err,
  output logic [15:0] frame_cnt
);

  state_t      state;
  logic [7:0]  addr_q;
  logic [7:0]  csum_acc;
  logic [31:0] data_sr;
  logic [1:0]  idx;
  logic        to_en;
  logic        to_tc;

  // Watchdog runs only inside a frame and restarts on every byte
  assign to_en = (state != IDLE);

  dds_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (rx_vld),
    .en      (to_en),
    .tc      (to_tc)
  );

  // Frame FSM with registered strobes. A byte on the terminal-count cycle
  // takes priority over the timeout, which keeps all pulses exclusive.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      csum_acc    <= '0;
      data_sr     <= '0;
      idx         <= '0;
      wr_vld      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      csum_err    <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      wr_vld      <= 1'b0;
      csum_err    <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      if (rx_vld) begin
        case (state)
          IDLE: if (rx_data == HDR0) state <= HDR;
          HDR: begin
            if (rx_data == HDR1)      state <= ADDR;
            else if (rx_data != HDR0) state <= IDLE;
            // repeated HDR0 keeps us in HDR to resync on the real header
          end
          ADDR: begin
            addr_q   <= rx_data;
            csum_acc <= rx_data;
            idx      <= 2'd0;
            state    <= DATA;
          end
          DATA: begin
            data_sr  <= {data_sr[23:0], rx_data};
            csum_acc <= csum_acc + rx_data;
            if (idx == 2'd3) state <= CSUM;
            else             idx   <= idx + 2'd1;
          end
          CSUM: begin
            state <= IDLE;
            // checksum is judged first so a corrupted address never
            // shows up as an address error
            if (rx_data != csum_acc) begin
              csum_err <= 1'b1;
            end else if (!addr_legal(addr_q, ADDR_MAX)) begin
              addr_err <= 1'b1;
            end else begin
              wr_vld    <= 1'b1;
              wr_addr   <= {24'h0, addr_q};
              wr_data   <= data_sr;
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (to_tc) begin
        state       <= IDLE;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser with a short watchdog for quick runs.
module tb_dds_cmd_parser;

  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_vld  = 1'b0;
  logic        wr_vld;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        csum_err;
  logic        addr_err;
  logic        timeout_err;
  logic [15:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  dds_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .wr_vld      (wr_vld),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .csum_err    (csum_err),
    .addr_err    (addr_err),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is captured at the next posedge and we
  // return at the following negedge, where registered outputs are visible.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge sys_clk);
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  function automatic logic [3:0] flags();
    return {wr_vld, csum_err, addr_err, timeout_err};
  endfunction

  initial begin
    idle(3);
    sys_rst = 1'b0;
    idle(1);

    // reset state
    chk("rst_flags", {28'h0, flags()}, 32'h0);
    chk("rst_addr", wr_addr, 32'h0);
    chk("rst_data", wr_data, 32'h0);
    chk("rst_cnt", {16'h0, frame_cnt}, 32'h0);

    // valid write to FREQ
    send(8'h55); send(8'hAA); send(8'h04); send(8'h00);
    send(8'h00); send(8'hA7); send(8'hC5);
    chk("pre_csum_wr", {31'h0, wr_vld}, 32'h0);
    send(8'h70);
    chk("w1_flags", {28'h0, flags()}, 32'h8);
    chk("w1_addr", wr_addr, 32'h0000_0004);
    chk("w1_data", wr_data, 32'h0000_A7C5);
    chk("w1_cnt", {16'h0, frame_cnt}, 32'd1);
    idle(1);
    chk("w1_pulse", {28'h0, flags()}, 32'h0);

    // checksum error: sum is 01, frame carries 02
    send(8'h55); send(8'hAA); send(8'h00); send(8'h00);
    send(8'h00); send(8'h01); send(8'h00); send(8'h02);
    chk("cs_flags", {28'h0, flags()}, 32'h4);
    chk("cs_addr", wr_addr, 32'h0000_0004);
    chk("cs_data", wr_data, 32'h0000_A7C5);
    chk("cs_cnt", {16'h0, frame_cnt}, 32'd1);
    idle(1);
    chk("cs_pulse", {28'h0, flags()}, 32'h0);

    // unaligned address
    send(8'h55); send(8'hAA); send(8'h05); send(8'h00);
    send(8'h00); send(8'h00); send(8'h01); send(8'h06);
    chk("ua_flags", {28'h0, flags()}, 32'h2);
    chk("ua_cnt", {16'h0, frame_cnt}, 32'd1);
    idle(1);

    // address above register map
    send(8'h55); send(8'hAA); send(8'h10); send(8'h00);
    send(8'h00); send(8'h00); send(8'h01); send(8'h11);
    chk("oor_flags", {28'h0, flags()}, 32'h2);
    chk("oor_cnt", {16'h0, frame_cnt}, 32'd1);
    chk("oor_data", wr_data, 32'h0000_A7C5);
    idle(1);

    // resync on repeated HDR0, highest legal address, then back-to-back
    send(8'h55); send(8'h55); send(8'hAA); send(8'h0C); send(8'h00);
    send(8'h00); send(8'h04); send(8'h00); send(8'h10);
    chk("rs_flags", {28'h0, flags()}, 32'h8);
    chk("rs_addr", wr_addr, 32'h0000_000C);
    chk("rs_data", wr_data, 32'h0000_0400);
    chk("rs_cnt", {16'h0, frame_cnt}, 32'd2);
    // 08+12+34+56+78 = 0x11C -> checksum 1C
    send(8'h55); send(8'hAA); send(8'h08); send(8'h12);
    send(8'h34); send(8'h56); send(8'h78); send(8'h1C);
    chk("bb_flags", {28'h0, flags()}, 32'h8);
    chk("bb_addr", wr_addr, 32'h0000_0008);
    chk("bb_data", wr_data, 32'h1234_5678);
    chk("bb_cnt", {16'h0, frame_cnt}, 32'd3);
    idle(1);

    // timeout: no byte for TO cycles inside a frame
    send(8'h55); send(8'hAA); send(8'h04); send(8'h00);
    idle(TO - 1);
    chk("to_early", {28'h0, flags()}, 32'h0);
    idle(1);
    chk("to_flags", {28'h0, flags()}, 32'h1);
    idle(1);
    chk("to_pulse", {28'h0, flags()}, 32'h0);
    send(8'h55); send(8'hAA); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00); send(8'h2A); send(8'h2A);
    chk("to_next_flags", {28'h0, flags()}, 32'h8);
    chk("to_next_data", wr_data, 32'h0000_002A);
    chk("to_next_cnt", {16'h0, frame_cnt}, 32'd4);
    idle(1);

    // byte arriving exactly on the terminal-count cycle wins
    send(8'h55); send(8'hAA); send(8'h04); send(8'h00);
    idle(TO - 1);
    send(8'h01);
    chk("tc_no_to", {28'h0, flags()}, 32'h0);
    send(8'h02); send(8'h03); send(8'h0A);
    chk("tc_flags", {28'h0, flags()}, 32'h8);
    chk("tc_data", wr_data, 32'h0001_0203);
    chk("tc_cnt", {16'h0, frame_cnt}, 32'd5);
    idle(1);

    // reset in the middle of a frame
    send(8'h55); send(8'hAA); send(8'h00); send(8'h11);
    sys_rst = 1'b1;
    idle(1);
    sys_rst = 1'b0;
    chk("mr_flags", {28'h0, flags()}, 32'h0);
    chk("mr_addr", wr_addr, 32'h0);
    chk("mr_data", wr_data, 32'h0);
    chk("mr_cnt", {16'h0, frame_cnt}, 32'd0);
    send(8'h22); chk("mr_b0", {28'h0, flags()}, 32'h0);
    send(8'h33); chk("mr_b1", {28'h0, flags()}, 32'h0);
    send(8'h44); chk("mr_b2", {28'h0, flags()}, 32'h0);
    send(8'h66); chk("mr_b3", {28'h0, flags()}, 32'h0);
    idle(TO + 2);
    chk("mr_quiet", {28'h0, flags()}, 32'h0);
    send(8'h55); send(8'hAA); send(8'h08); send(8'h00);
    send(8'h00); send(8'h00); send(8'h05); send(8'h0D);
    chk("mr_next_flags", {28'h0, flags()}, 32'h8);
    chk("mr_next_addr", wr_addr, 32'h0000_0008);
    chk("mr_next_data", wr_data, 32'h0000_0005);
    chk("mr_next_cnt", {16'h0, frame_cnt}, 32'd1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
